ps2_key_decoder: RTL and testbench

- Sits between the PS/2 receive interface and the two paddle blocks.
- Consumes received scan-code bytes (Set 2) and tracks E0 (extended) and F0 (break) prefixes with a small FSM.
- Produces registered held-key levels for left/right paddle up/down and a one-cycle pause pulse.
- Runs on the 100 MHz system clock; paddle blocks sample the levels on their own slow tick.

---
 rtl/ps2_key_decoder.sv | 156 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set 2 scan-code decoder producing paddle key levels and a pause pulse
module ps2_key_decoder #(
  parameter logic [7:0]  KEY_L_UP  = 8'h1D,
  parameter logic [7:0]  KEY_L_DN  = 8'h1B,
  parameter logic [7:0]  KEY_R_UP  = 8'h75,
  parameter logic [7:0]  KEY_R_DN  = 8'h72,
  parameter logic [7:0]  KEY_PAUSE = 8'h29,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       read_data,
  input  logic       err,
  output logic       left_up,
  output logic       left_down,
  output logic       right_up,
  output logic       right_down,
  output logic       pause_pulse,
  output logic       in_sequence
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          left_up_q, left_up_d;
  logic          left_down_q, left_down_d;
  logic          right_up_q, right_up_d;
  logic          right_down_q, right_down_d;
  logic          pause_q, pause_d;
  logic          space_held_q, space_held_d;
  logic          in_seq_q;

  // Next-state, prefix timeout and key-level update; err overrides any byte in the same cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    left_up_d    = left_up_q;
    left_down_d  = left_down_q;
    right_up_d   = right_up_q;
    right_down_d = right_down_q;
    pause_d      = 1'b0;
    space_held_d = space_held_q;

    if (err) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (read_data) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == PFX_EXT) begin
            state_d = EXT;
          end else if (rx_data == PFX_BRK) begin
            state_d = BRK;
          end else if (rx_data == KEY_L_UP) begin
            left_up_d = 1'b1;
          end else if (rx_data == KEY_L_DN) begin
            left_down_d = 1'b1;
          end else if (rx_data == KEY_PAUSE) begin
            // Typematic repeats keep space_held set, so only the first make pulses
            if (!space_held_q) begin
              pause_d      = 1'b1;
              space_held_d = 1'b1;
            end
          end
        end
        EXT: begin
          state_d = IDLE;
          if (rx_data == PFX_BRK) begin
            state_d = EXT_BRK;
          end else if (rx_data == PFX_EXT) begin
            state_d = EXT;
          end else if (rx_data == KEY_R_UP) begin
            right_up_d = 1'b1;
          end else if (rx_data == KEY_R_DN) begin
            right_down_d = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (rx_data == KEY_L_UP) begin
            left_up_d = 1'b0;
          end else if (rx_data == KEY_L_DN) begin
            left_down_d = 1'b0;
          end else if (rx_data == KEY_PAUSE) begin
            space_held_d = 1'b0;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (rx_data == KEY_R_UP) begin
            right_up_d = 1'b0;
          end else if (rx_data == KEY_R_DN) begin
            right_down_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A prefix with no follow-up byte is abandoned; held levels stay as they are
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      left_up_q    <= 1'b0;
      left_down_q  <= 1'b0;
      right_up_q   <= 1'b0;
      right_down_q <= 1'b0;
      pause_q      <= 1'b0;
      space_held_q <= 1'b0;
      in_seq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      left_up_q    <= left_up_d;
      left_down_q  <= left_down_d;
      right_up_q   <= right_up_d;
      right_down_q <= right_down_d;
      pause_q      <= pause_d;
      space_held_q <= space_held_d;
      in_seq_q     <= (state_d != IDLE);
    end
  end

  assign left_up     = left_up_q;
  assign left_down   = left_down_q;
  assign right_up    = right_up_q;
  assign right_down  = right_down_q;
  assign pause_pulse = pause_q;
  assign in_sequence = in_seq_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       read_data = 1'b0;
  logic       err = 1'b0;
  logic       left_up, left_down, right_up, right_down, pause_pulse, in_sequence;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  ps2_key_decoder #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .read_data   (read_data),
    .err         (err),
    .left_up     (left_up),
    .left_down   (left_down),
    .right_up    (right_up),
    .right_down  (right_down),
    .pause_pulse (pause_pulse),
    .in_sequence (in_sequence)
  );

  always #5 clk = ~clk;

  // Count pause pulses as seen midway between edges
  always @(negedge clk) begin
    if (!reset && pause_pulse) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single cycle; returns on the negedge after the sampling edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data   = b;
    read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
  endtask

  task automatic pulse_err(input logic with_byte, input logic [7:0] b);
    @(negedge clk);
    err       = 1'b1;
    read_data = with_byte;
    rx_data   = b;
    @(negedge clk);
    err       = 1'b0;
    read_data = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'd0, left_up, left_down, right_up, right_down, pause_pulse, in_sequence}, 32'd0);
  endtask

  initial begin
    // Reset
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(1);

    // Left up make / break
    send(8'h1D);
    check("l_up_make", left_up, 1'b1);
    send(8'hF0);
    check("brk_in_seq", in_sequence, 1'b1);
    check("brk_l_up_held", left_up, 1'b1);
    send(8'h1D);
    check("l_up_break", left_up, 1'b0);
    check("brk_done_in_seq", in_sequence, 1'b0);

    // Right up extended make / break, lone non-extended code ignored
    send(8'hE0);
    check("ext_in_seq", in_sequence, 1'b1);
    send(8'h75);
    check("r_up_make", right_up, 1'b1);
    send(8'hE0);
    send(8'hF0);
    check("extbrk_in_seq", in_sequence, 1'b1);
    send(8'h75);
    check("r_up_break", right_up, 1'b0);
    send(8'h75);
    check("lone_75", right_up, 1'b0);
    send(8'h72);
    check("lone_72", right_down, 1'b0);
    send(8'hE0);
    send(8'h1D);
    check("ext_1d_ignored", left_up, 1'b0);
    check("ext_1d_idle", in_sequence, 1'b0);

    // Pause: first make pulses, repeats do not, release re-arms
    send(8'h29);
    check("pause_first", pause_pulse, 1'b1);
    idle(1);
    check("pause_one_cycle", pause_pulse, 1'b0);
    send(8'h29);
    check("pause_rep1", pause_pulse, 1'b0);
    send(8'h29);
    check("pause_rep2", pause_pulse, 1'b0);
    send(8'hF0);
    send(8'h29);
    check("pause_release", pause_pulse, 1'b0);
    send(8'h29);
    check("pause_second", pause_pulse, 1'b1);
    idle(2);
    check("pause_total", pulses, 32'd2);

    // Simultaneous up and down held
    send(8'h1D);
    send(8'h1B);
    check("both_up", left_up, 1'b1);
    check("both_dn", left_down, 1'b1);
    send(8'hF0);
    send(8'h1B);
    check("dn_break", left_down, 1'b0);
    check("up_kept", left_up, 1'b1);

    // Error aborts a break prefix
    send(8'hF0);
    pulse_err(1'b0, 8'h00);
    check("err_idle", in_sequence, 1'b0);
    send(8'h1B);
    check("err_then_make", left_down, 1'b1);
    send(8'hF0);
    send(8'h1D);
    check("l_up_cleared", left_up, 1'b0);
    pulse_err(1'b1, 8'h1D);
    check("err_wins_byte", left_up, 1'b0);
    check("err_keeps_dn", left_down, 1'b1);
    pulse_err(1'b1, 8'hF0);
    check("err_wins_prefix", in_sequence, 1'b0);

    // Timeout boundary: still in sequence one cycle before, idle at TIMEOUT
    send(8'hE0);
    idle(T - 1);
    check("to_before", in_sequence, 1'b1);
    idle(1);
    check("to_expired", in_sequence, 1'b0);
    send(8'h75);
    check("to_75_ignored", right_up, 1'b0);
    check("to_keeps_dn", left_down, 1'b1);

    // Reset mid-sequence
    send(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_reset");
    send(8'h75);
    check("reset_75_ignored", right_up, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
